instr_fetch_unit: RTL

// Upstream end of the decode interface: produces the 32-bit instruction word that control_unit decodes.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_pc_reg.sv | 30 +++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Instruction addresses are word aligned; the two low bits are always dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset, redirect load and sequential increment.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_pc,
    input  logic        i_incr,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // A redirect wins over the increment when both land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= align_pc(i_load_pc);
        end else if (i_incr) begin
            r_pc <= r_pc + PC_INCR;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory read, registered hand-off to decode,
// redirect from execute with stale-response discard.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output fetch_state_t dbg_state
);

    // Decode handshake: instr/instr_pc are stable while instr_valid=1 and the word
    // is consumed on any rising edge where instr_valid=1 and instr_ready=1.
    fetch_state_t r_state;
    logic         r_discard;
    logic         r_imem_req;
    logic         r_instr_valid;
    logic [31:0]  r_instr;
    logic [31:0]  r_instr_pc;
    logic [31:0]  w_pc;
    logic         w_handshake;

    assign w_handshake = (r_state == HOLD) && instr_ready;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .i_load    (redirect),
        .i_load_pc (redirect_pc),
        .i_incr    (w_handshake),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= REQ;
            r_discard     <= 1'b0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
        end else begin
            r_imem_req <= 1'b0;
            if (redirect) begin
                r_instr_valid <= 1'b0;
                r_instr       <= NOP_INSTR;
                // An in-flight read must still drain; its data is thrown away.
                if ((r_state == WAIT) && !imem_rvalid) begin
                    r_discard <= 1'b1;
                end else begin
                    r_discard  <= 1'b0;
                    r_state    <= REQ;
                    r_imem_req <= 1'b1;
                end
            end else begin
                case (r_state)
                    REQ: begin
                        // Right after reset REQ is entered with no request pending.
                        if (r_imem_req) begin
                            r_state <= WAIT;
                        end else begin
                            r_imem_req <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (r_discard) begin
                                r_discard  <= 1'b0;
                                r_state    <= REQ;
                                r_imem_req <= 1'b1;
                            end else begin
                                r_instr       <= imem_rdata;
                                r_instr_pc    <= w_pc;
                                r_instr_valid <= 1'b1;
                                r_state       <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            r_instr_valid <= 1'b0;
                            r_instr       <= NOP_INSTR;
                            r_state       <= REQ;
                            r_imem_req    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= REQ;
                    end
                endcase
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = w_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign dbg_state   = r_state;

endmodule
